pwm: RTL and testbench

Fixed-frequency pulse-width modulator whose duty cycle is adjusted in 10 % steps by two push-button style inputs. Each rising edge on `inc` raises the duty by one step and each rising edge on `dec` lowers it by one step, saturating at 0 % and 100 %. It sits at the edge of the design, between user or controller pulse inputs and a single PWM output pin.

---
 rtl/pwm_pkg.sv | 18 +
 rtl/pwm_edge_sync.sv | 32 +++
 rtl/pwm.sv | 74 +++++++
 tb/tb_pwm.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared defaults and width helpers for the push-button controlled PWM.
package pwm_pkg;

  localparam int STEPS_DEFAULT       = 10;
  localparam int DUTY_INIT_DEFAULT   = 5;
  localparam int SYNC_STAGES_DEFAULT = 2;

  // Period counter spans 0..steps-1; keep at least one bit for the degenerate case.
  function automatic int cnt_width(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

  // Duty spans 0..steps inclusive, so one extra code is needed.
  function automatic int duty_width(input int steps);
    return $clog2(steps + 1);
  endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronizes an asynchronous level and emits a one-cycle registered pulse per rising edge.
module pwm_edge_sync
  import pwm_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
      pulse  <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/pwm.sv
// Fixed-period PWM whose duty moves in 1/STEPS increments on inc/dec rising edges.
module pwm
  import pwm_pkg::*;
#(
  parameter int STEPS       = STEPS_DEFAULT,
  parameter int DUTY_INIT   = DUTY_INIT_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic PWM_out
);

  localparam int CW = cnt_width(STEPS);
  localparam int DW = duty_width(STEPS);

  localparam logic [CW-1:0] CNT_LAST  = CW'(STEPS - 1);
  localparam logic [DW-1:0] DUTY_MAX  = DW'(STEPS);
  localparam logic [DW-1:0] DUTY_RST  = DW'(DUTY_INIT);
  localparam logic [DW-1:0] DUTY_STEP = DW'(1);

  logic          inc_pulse;
  logic          dec_pulse;
  logic [CW-1:0] cnt;
  logic [DW-1:0] duty_req;
  logic [DW-1:0] duty_req_nxt;
  logic [DW-1:0] duty_act;

  pwm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_inc_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (inc),
    .pulse (inc_pulse)
  );

  pwm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dec_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (dec),
    .pulse (dec_pulse)
  );

  // NOTE: default assignment first so no path leaves duty_req_nxt unassigned (no latch).
  always_comb begin
    duty_req_nxt = duty_req;
    if (inc_pulse && !dec_pulse && (duty_req != DUTY_MAX)) begin
      duty_req_nxt = duty_req + DUTY_STEP;
    end else if (dec_pulse && !inc_pulse && (duty_req != '0)) begin
      duty_req_nxt = duty_req - DUTY_STEP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      duty_req <= DUTY_RST;
      duty_act <= DUTY_RST;
      PWM_out  <= 1'b0;
    end else begin
      duty_req <= duty_req_nxt;
      // Shadow copy only at the wrap so a period never mixes two duty values.
      if (cnt == CNT_LAST) begin
        cnt      <= '0;
        duty_act <= duty_req;
      end else begin
        cnt <= cnt + CW'(1);
      end
      PWM_out <= (DW'(cnt) < duty_act);
    end
  end

endmodule

// File: tb/tb_pwm.sv
// Directed bench for pwm: table of step sequences plus hand-written latency and reset cases.
module tb_pwm;

  logic clk = 1'b0;
  logic rst;
  logic inc;
  logic dec;
  logic PWM_out;

  int checks = 0;
  int errors = 0;
  int cyc;

  typedef enum {PULSE_INC, PULSE_DEC, PULSE_BOTH, DO_RESET} kind_e;

  typedef struct {
    string name;
    kind_e kind;
    int    count;
    int    exp_duty;
  } vec_t;

  vec_t vecs[$];

  pwm dut (
    .clk     (clk),
    .rst     (rst),
    .inc     (inc),
    .dec     (dec),
    .PWM_out (PWM_out)
  );

  always #5 clk = ~clk;

  // Edges since reset release; after edge k the output reflects the compare for cnt=(k-1)%10.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  function automatic int duty_pattern(input int d);
    return ((1 << d) - 1) & 32'h3FF;
  endfunction

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Step to a negedge that directly follows a period boundary edge.
  task automatic align(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cyc % 10 == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check({name, "_align"}, 0, 1);
  endtask

  // Records one full period; bit i is the output for cnt=i.
  task automatic capture(output int pat);
    pat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (PWM_out) pat = pat | (1 << i);
    end
  endtask

  task automatic pulse(input bit p_inc, input bit p_dec);
    inc = p_inc;
    dec = p_dec;
    wait_neg(4);
    inc = 1'b0;
    dec = 1'b0;
    wait_neg(4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_neg(2);
    rst = 1'b0;
  endtask

  initial begin
    int pat;

    rst = 1'b1;
    inc = 1'b0;
    dec = 1'b0;
    #1;
    check("reset_out", int'(PWM_out), 0);
    wait_neg(3);
    rst = 1'b0;

    capture(pat);
    check("init_50pct", pat, duty_pattern(5));

    // inc rises mid-way between boundary edges: current period keeps 50 %, the next is 60 %.
    inc = 1'b1;
    capture(pat);
    check("hold_inc_same_period", pat, duty_pattern(5));
    capture(pat);
    check("hold_inc_next_period", pat, duty_pattern(6));
    inc = 1'b0;
    wait_neg(25);
    align("hold_inc_release");
    capture(pat);
    check("hold_inc_single_step", pat, duty_pattern(6));

    vecs.push_back('{"dec_to_50",     PULSE_DEC,  1, 5});
    vecs.push_back('{"inc5_to_100",   PULSE_INC,  5, 10});
    vecs.push_back('{"inc_sat_100",   PULSE_INC,  1, 10});
    vecs.push_back('{"reset_to_50",   DO_RESET,   1, 5});
    vecs.push_back('{"dec6_to_0",     PULSE_DEC,  6, 0});
    vecs.push_back('{"dec_sat_0",     PULSE_DEC,  1, 0});
    vecs.push_back('{"reset_again",   DO_RESET,   1, 5});
    vecs.push_back('{"both_same_cyc", PULSE_BOTH, 1, 5});
    vecs.push_back('{"inc_to_60",     PULSE_INC,  1, 6});
    vecs.push_back('{"dec_back_50",   PULSE_DEC,  1, 5});
    vecs.push_back('{"inc3_to_80",    PULSE_INC,  3, 8});

    foreach (vecs[v]) begin
      for (int n = 0; n < vecs[v].count; n++) begin
        case (vecs[v].kind)
          PULSE_INC:  pulse(1'b1, 1'b0);
          PULSE_DEC:  pulse(1'b0, 1'b1);
          PULSE_BOTH: pulse(1'b1, 1'b1);
          default:    do_reset();
        endcase
      end
      wait_neg(25);
      align(vecs[v].name);
      capture(pat);
      check(vecs[v].name, pat, duty_pattern(vecs[v].exp_duty));
    end

    // Reset mid-period while the output is high at 80 %.
    align("mid_rst");
    wait_neg(3);
    check("pre_rst_high", int'(PWM_out), 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_low", int'(PWM_out), 0);
    wait_neg(2);
    check("rst_held_low", int'(PWM_out), 0);
    rst = 1'b0;
    capture(pat);
    check("post_rst_50pct", pat, duty_pattern(5));
    capture(pat);
    check("post_rst_period2", pat, duty_pattern(5));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
